// File: rtl/altera_tse_pma_reset_ctrl_mc.sv
// Multi-channel LVDS/PMA receive reset sequencer: PLL reset, lock wait, CDA reset, word align, run.
// Define TSE_PMA_RST_RETRY_CNT_EN to add the saturating retry_count output.
module altera_tse_pma_reset_ctrl_mc #(
  parameter int NUM_CH         = 2,
  parameter int SYNC_DEPTH     = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int ALIGN_PULSES   = 4
) (
  input  logic              clk,
  input  logic              reset_rx_clk,
  input  logic [NUM_CH-1:0] rx_locked,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic              pll_areset,
  output logic [NUM_CH-1:0] rx_reset,
  output logic [NUM_CH-1:0] rx_cda_reset,
  output logic [NUM_CH-1:0] rx_channel_data_align,
  output logic [NUM_CH-1:0] pcs_rx_reset,
`ifdef TSE_PMA_RST_RETRY_CNT_EN
  output logic [7:0]        retry_count,
`endif
  output logic              ready
);

  localparam int CDA_CYCLES   = 4;
  localparam int ALIGN_CYCLES = 2 * ALIGN_PULSES;
  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (ALIGN_CYCLES > CDA_CYCLES) ? ALIGN_CYCLES : CDA_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PLL_LAST   = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] CDA_LAST   = CW'(CDA_CYCLES - 1);
  localparam logic [CW-1:0] ALIGN_LAST = CW'(ALIGN_CYCLES - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, CDA_RST, ALIGN, RUN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cntLimit;
  logic [NUM_CH-1:0] enable_q;
  logic [NUM_CH-1:0] lockSync_q [SYNC_DEPTH];
  logic [NUM_CH-1:0] lockS;
  logic              allLocked, lockLost, enChanged;
  logic              pllAreset_d, ready_d;
  logic [NUM_CH-1:0] rxReset_d, cdaReset_d, align_d, pcsReset_d;

  always_ff @(posedge clk or posedge reset_rx_clk) begin
    if (reset_rx_clk) begin
      for (int i = 0; i < SYNC_DEPTH; i++) lockSync_q[i] <= '0;
    end else begin
      lockSync_q[0] <= rx_locked;
      for (int i = 1; i < SYNC_DEPTH; i++) lockSync_q[i] <= lockSync_q[i-1];
    end
  end

  assign lockS     = lockSync_q[SYNC_DEPTH-1];
  assign allLocked = ((lockS & ch_enable) == ch_enable) && (ch_enable != '0);
  assign lockLost  = (lockS & ch_enable) != ch_enable;
  assign enChanged = ch_enable != enable_q;

  // Any exit back to PLL_RST from another state counts as a restart.
  always_comb begin
    state_d  = state_q;
    cntLimit = '0;
    case (state_q)
      PLL_RST: begin
        cntLimit = PLL_LAST;
        if (cnt_q == PLL_LAST && ch_enable != '0) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        cntLimit = LOCK_LAST;
        if (enChanged)               state_d = PLL_RST;
        else if (allLocked)          state_d = CDA_RST;
        else if (cnt_q == LOCK_LAST) state_d = PLL_RST;
      end
      CDA_RST: begin
        cntLimit = CDA_LAST;
        if (enChanged || lockLost)  state_d = PLL_RST;
        else if (cnt_q == CDA_LAST) state_d = ALIGN;
      end
      ALIGN: begin
        cntLimit = ALIGN_LAST;
        if (enChanged || lockLost)    state_d = PLL_RST;
        else if (cnt_q == ALIGN_LAST) state_d = RUN;
      end
      RUN: begin
        if (enChanged || lockLost) state_d = PLL_RST;
      end
      default: state_d = PLL_RST;
    endcase

    if (state_d != state_q)   cnt_d = '0;
    else if (cnt_q != cntLimit) cnt_d = cnt_q + ONE;
    else                      cnt_d = cnt_q;
  end

  // Outputs are decoded from the next state so the registered values line up with the state.
  always_comb begin
    pllAreset_d = 1'b1;
    ready_d     = 1'b0;
    rxReset_d   = '1;
    cdaReset_d  = '1;
    align_d     = '0;
    pcsReset_d  = '1;
    case (state_d)
      WAIT_LOCK: pllAreset_d = 1'b0;
      CDA_RST: begin
        pllAreset_d = 1'b0;
        rxReset_d   = ~ch_enable;
      end
      ALIGN: begin
        pllAreset_d = 1'b0;
        rxReset_d   = ~ch_enable;
        cdaReset_d  = ~ch_enable;
        align_d     = cnt_d[0] ? '0 : ch_enable;
      end
      RUN: begin
        pllAreset_d = 1'b0;
        rxReset_d   = ~ch_enable;
        cdaReset_d  = ~ch_enable;
        pcsReset_d  = ~ch_enable;
        ready_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_rx_clk) begin
    if (reset_rx_clk) begin
      state_q               <= PLL_RST;
      cnt_q                 <= '0;
      enable_q              <= '0;
      pll_areset            <= 1'b1;
      rx_reset              <= '1;
      rx_cda_reset          <= '1;
      rx_channel_data_align <= '0;
      pcs_rx_reset          <= '1;
      ready                 <= 1'b0;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      enable_q              <= ch_enable;
      pll_areset            <= pllAreset_d;
      rx_reset              <= rxReset_d;
      rx_cda_reset          <= cdaReset_d;
      rx_channel_data_align <= align_d;
      pcs_rx_reset          <= pcsReset_d;
      ready                 <= ready_d;
    end
  end

`ifdef TSE_PMA_RST_RETRY_CNT_EN
  logic [7:0] retry_q;

  always_ff @(posedge clk or posedge reset_rx_clk) begin
    if (reset_rx_clk) begin
      retry_q <= 8'd0;
    end else if (state_q != PLL_RST && state_d == PLL_RST && retry_q != 8'hFF) begin
      retry_q <= retry_q + 8'd1;
    end
  end

  assign retry_count = retry_q;
`endif

endmodule

// File: tb/tb_altera_tse_pma_reset_ctrl_mc.sv
// Scoreboard bench for altera_tse_pma_reset_ctrl_mc: stimulus queues per-cycle expectations, a monitor checks them.
// Covers retry_count as well when TSE_PMA_RST_RETRY_CNT_EN is defined.
module tb_altera_tse_pma_reset_ctrl_mc;

  logic       clk = 1'b0;
  logic       reset_rx_clk = 1'b1;
  logic [1:0] rx_locked = 2'b00;
  logic [1:0] ch_enable = 2'b00;
  logic       pll_areset, ready;
  logic [1:0] rx_reset, rx_cda_reset, rx_channel_data_align, pcs_rx_reset;
`ifdef TSE_PMA_RST_RETRY_CNT_EN
  logic [7:0] retry_count;
`endif

  altera_tse_pma_reset_ctrl_mc #(
    .NUM_CH(2), .SYNC_DEPTH(3), .PLL_RST_CYCLES(8), .LOCK_TIMEOUT(100), .ALIGN_PULSES(2)
  ) dut (
    .clk(clk),
    .reset_rx_clk(reset_rx_clk),
    .rx_locked(rx_locked),
    .ch_enable(ch_enable),
    .pll_areset(pll_areset),
    .rx_reset(rx_reset),
    .rx_cda_reset(rx_cda_reset),
    .rx_channel_data_align(rx_channel_data_align),
    .pcs_rx_reset(pcs_rx_reset),
`ifdef TSE_PMA_RST_RETRY_CNT_EN
    .retry_count(retry_count),
`endif
    .ready(ready)
  );

  always #5 clk = ~clk;

  typedef enum int {S_PLL, S_WAIT, S_CDA, S_ALIGN, S_RUN} st_t;
  typedef struct {
    string      tag;
    logic [9:0] vec;
    logic [7:0] retry;
  } exp_t;

  localparam logic [9:0] RESET_VEC = 10'b1_11_11_00_11_0;

  exp_t       expQ[$];
  int         nCompared = 0;
  int         nMismatched = 0;
  logic [7:0] expRetry = 8'd0;

  // Expected {pll, rx_reset, cda_reset, align, pcs_reset, ready} for a state; disabled lanes forced idle.
  function automatic logic [9:0] expVec(st_t st, logic [1:0] en, logic alnHi);
    logic       pll, rdy;
    logic [1:0] rxr, cda, aln, pcs;
    pll = 1'b1; rdy = 1'b0; rxr = 2'b11; cda = 2'b11; aln = 2'b00; pcs = 2'b11;
    case (st)
      S_WAIT:  pll = 1'b0;
      S_CDA:   begin pll = 1'b0; rxr = 2'b00; end
      S_ALIGN: begin pll = 1'b0; rxr = 2'b00; cda = 2'b00; aln = alnHi ? 2'b11 : 2'b00; end
      S_RUN:   begin pll = 1'b0; rxr = 2'b00; cda = 2'b00; pcs = 2'b00; rdy = 1'b1; end
      default: ;
    endcase
    rxr = rxr | ~en;
    cda = cda | ~en;
    aln = aln & en;
    pcs = pcs | ~en;
    return {pll, rxr, cda, aln, pcs, rdy};
  endfunction

  task automatic applyStimulus(input string tag, input st_t st, input logic [1:0] en, input logic alnHi);
    exp_t e;
    @(negedge clk);
    e.tag = tag;
    e.vec = expVec(st, en, alnHi);
    e.retry = expRetry;
    expQ.push_back(e);
  endtask

  task automatic resetCycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_rx_clk = 1'b1;
      expRetry = 8'd0;
      e.tag = "reset";
      e.vec = RESET_VEC;
      e.retry = 8'd0;
      expQ.push_back(e);
    end
  endtask

  task automatic expectPll(input int n, input logic [1:0] en);
    for (int i = 0; i < n; i++) applyStimulus("pll_rst", S_PLL, en, 1'b0);
  endtask

  task automatic expectWait(input int n, input logic [1:0] en);
    for (int i = 0; i < n; i++) applyStimulus("wait_lock", S_WAIT, en, 1'b0);
  endtask

  task automatic expectCda(input logic [1:0] en);
    for (int i = 0; i < 4; i++) applyStimulus("cda_rst", S_CDA, en, 1'b0);
  endtask

  task automatic expectAlign(input int n, input logic [1:0] en);
    for (int i = 0; i < n; i++) applyStimulus("align", S_ALIGN, en, (i % 2) == 0);
  endtask

  task automatic expectRun(input int n, input logic [1:0] en);
    for (int i = 0; i < n; i++) applyStimulus("run", S_RUN, en, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [9:0] actual;
    actual = {pll_areset, rx_reset, rx_cda_reset, rx_channel_data_align, pcs_rx_reset, ready};
    nCompared++;
    if (actual !== e.vec) begin
      nMismatched++;
      $display("[TB] FAIL %s @%0t: outputs got %b want %b (pll,rxr,cda,aln,pcs,rdy)",
               e.tag, $time, actual, e.vec);
    end
`ifdef TSE_PMA_RST_RETRY_CNT_EN
    nCompared++;
    if (retry_count !== e.retry) begin
      nMismatched++;
      $display("[TB] FAIL %s_retry @%0t: retry_count got %0d want %0d", e.tag, $time, retry_count, e.retry);
    end
`endif
  endtask

  // Monitor: checks one queued expectation per cycle, just after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    // Full bring-up with both lanes enabled and locked
    ch_enable = 2'b11;
    rx_locked = 2'b11;
    resetCycles(3);
    reset_rx_clk = 1'b0;
    expectPll(7, 2'b11);
    expectWait(1, 2'b11);
    expectCda(2'b11);
    expectAlign(4, 2'b11);
    expectRun(5, 2'b11);

    // Lane 1 loses lock in RUN; restart after the synchronizer delay
    rx_locked = 2'b01;
    expectRun(3, 2'b11);
    expRetry = 8'd1;
    expectPll(1, 2'b11);
    rx_locked = 2'b11;
    expectPll(7, 2'b11);
    expectWait(1, 2'b11);
    expectCda(2'b11);
    expectAlign(4, 2'b11);
    expectRun(3, 2'b11);

    // Reset asserted in the middle of ALIGN
    resetCycles(2);
    reset_rx_clk = 1'b0;
    expectPll(7, 2'b11);
    expectWait(1, 2'b11);
    expectCda(2'b11);
    expectAlign(3, 2'b11);
    resetCycles(3);
    reset_rx_clk = 1'b0;
    expectPll(7, 2'b11);
    expectWait(1, 2'b11);
    expectCda(2'b11);
    expectAlign(4, 2'b11);
    expectRun(2, 2'b11);

    // Only lane 0 enabled; lane 1 must stay idle throughout
    ch_enable = 2'b01;
    rx_locked = 2'b01;
    resetCycles(2);
    reset_rx_clk = 1'b0;
    expectPll(7, 2'b01);
    expectWait(1, 2'b01);
    expectCda(2'b01);
    expectAlign(4, 2'b01);
    expectRun(4, 2'b01);

    // Enabling lane 1 in RUN forces a restart
    ch_enable = 2'b11;
    rx_locked = 2'b11;
    expRetry = 8'd1;
    expectPll(8, 2'b11);
    expectWait(1, 2'b11);
    expectCda(2'b11);
    expectAlign(4, 2'b11);
    expectRun(2, 2'b11);

    // No lanes enabled: parked in PLL_RST
    ch_enable = 2'b00;
    expRetry = 8'd2;
    expectPll(20, 2'b00);

    // Lane 1 never locks: WAIT_LOCK times out twice
    ch_enable = 2'b11;
    rx_locked = 2'b01;
    resetCycles(2);
    reset_rx_clk = 1'b0;
    expectPll(7, 2'b11);
    expectWait(100, 2'b11);
    expRetry = 8'd1;
    expectPll(8, 2'b11);
    expectWait(100, 2'b11);
    expRetry = 8'd2;
    expectPll(8, 2'b11);
    expectWait(3, 2'b11);

    #3;
    if (expQ.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL drain: pending expectations got %0d want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
